// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signal bundle of the direct-mapped instruction cache.
// slave is the cache's view; master is the fetcher/memory-model view.
interface icache_direct_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [1:0]            rw_flag;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  flush;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  busy;
    logic                  done;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  rw_flag, addr, flush, mem_ack, mem_rdata,
        output read_data, busy, done, mem_req, mem_addr
    );

    modport master (
        output rw_flag, addr, flush, mem_ack, mem_rdata,
        input  read_data, busy, done, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_direct.sv
// Read-only direct-mapped instruction cache: 1-cycle hits, whole-line refill over a
// word-wide req/ack port, and fence.i flush that is deferred while a refill is running.
module icache_direct #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned LINE_WORDS = 4
) (
    input logic            clk,
    input logic            rst,
    icache_direct_if.slave bus
);
    localparam int unsigned OFF            = $clog2(LINE_WORDS);
    localparam int unsigned TAG_LSB        = 2 + OFF + INDEX_BITS;
    localparam int unsigned TAG_BITS       = ADDR_WIDTH - TAG_LSB;
    localparam int unsigned LINES          = 1 << INDEX_BITS;
    localparam int unsigned LINE_ADDR_BITS = ADDR_WIDTH - 2 - OFF;
    localparam logic [OFF-1:0] LAST        = OFF'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, FILLDONE} state_t;

    state_t                    state_q, state_d;
    logic [LINES-1:0]          valid_q, valid_d;
    logic [LINE_ADDR_BITS-1:0] line_q, line_d;
    logic [OFF-1:0]            off_q, off_d;
    logic [OFF-1:0]            cnt_q, cnt_d;
    logic                      flush_pending_q, flush_pending_d;
    logic                      done_q, done_d;
    logic [DATA_WIDTH-1:0]     read_data_q, read_data_d;

    // Arrays carry no reset; the valid bits alone decide what is resident.
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES*LINE_WORDS];
    logic [DATA_WIDTH-1:0] fill_buf [LINE_WORDS];

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [OFF-1:0]        req_off;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;
    logic                  unused_bits;

    assign req_index  = bus.addr[2+OFF +: INDEX_BITS];
    assign req_tag    = bus.addr[TAG_LSB +: TAG_BITS];
    assign req_off    = bus.addr[2 +: OFF];
    assign fill_index = line_q[INDEX_BITS-1:0];
    assign fill_tag   = line_q[INDEX_BITS +: TAG_BITS];
    assign hit        = valid_q[req_index] && (tag_mem[req_index] == req_tag) && !bus.flush;

    assign unused_bits = ^{bus.rw_flag[1], bus.addr[1:0]};

    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        line_d          = line_q;
        off_d           = off_q;
        cnt_d           = cnt_q;
        flush_pending_d = flush_pending_q;
        done_d          = 1'b0;
        read_data_d     = read_data_q;
        unique case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    valid_d = '0;
                end
                if (bus.rw_flag[0]) begin
                    line_d = bus.addr[ADDR_WIDTH-1 -: LINE_ADDR_BITS];
                    off_d  = req_off;
                    if (hit) begin
                        done_d      = 1'b1;
                        read_data_d = data_mem[{req_index, req_off}];
                    end else begin
                        state_d = REFILL;
                        cnt_d   = '0;
                    end
                end
            end
            REFILL: begin
                if (bus.flush) begin
                    flush_pending_d = 1'b1;
                end
                if (bus.mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d         = FILLDONE;
                        done_d          = 1'b1;
                        flush_pending_d = 1'b0;
                        // The requested word may be the one arriving right now.
                        read_data_d = (off_q == LAST) ? bus.mem_rdata : fill_buf[off_q];
                        if (flush_pending_q || bus.flush) begin
                            valid_d = '0;
                        end else begin
                            valid_d[fill_index] = 1'b1;
                        end
                    end
                end
            end
            FILLDONE: begin
                if (bus.flush) begin
                    valid_d = '0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            line_q          <= '0;
            off_q           <= '0;
            cnt_q           <= '0;
            flush_pending_q <= 1'b0;
            done_q          <= 1'b0;
            read_data_q     <= '0;
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            line_q          <= line_d;
            off_q           <= off_d;
            cnt_q           <= cnt_d;
            flush_pending_q <= flush_pending_d;
            done_q          <= done_d;
            read_data_q     <= read_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == REFILL) && bus.mem_ack) begin
            data_mem[{fill_index, cnt_q}] <= bus.mem_rdata;
            fill_buf[cnt_q]               <= bus.mem_rdata;
            if (cnt_q == LAST) begin
                tag_mem[fill_index] <= fill_tag;
            end
        end
    end

    assign bus.busy      = (state_q == REFILL);
    assign bus.mem_req   = (state_q == REFILL);
    assign bus.mem_addr  = {line_q, cnt_q, 2'b00};
    assign bus.done      = done_q;
    assign bus.read_data = read_data_q;
endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: a residency model predicts hit/miss and data,
// a memory responder checks the refill address stream, a monitor checks every done.
module tb_icache_direct;
    logic clk = 1'b0;
    logic rst = 1'b0;

    icache_direct_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    icache_direct #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .INDEX_BITS(6),
        .LINE_WORDS(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          miss;
    } exp_t;

    int checks = 0;
    int failures = 0;

    exp_t        sbq[$];
    logic [31:0] addrq[$];

    // Residency model: which line tag each index currently holds.
    bit          m_valid[64];
    logic [21:0] m_tag[64];

    int ack_delay = 2;
    bit rand_delay = 0;
    int cur_delay = 2;
    int wait_cnt = 0;
    int ack_count = 0;
    int busy_cycles = 0;
    int mreq_cycles = 0;
    int done_count = 0;
    bit saw_busy = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(logic [31:0] a);
        logic [31:0] w;
        w = {2'b00, a[31:2]};
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void model_clear();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
    endfunction

    // Push expectations for a read; returns whether the model predicts a miss.
    function automatic bit predict(logic [31:0] a, bit fl, bit validate);
        exp_t       e;
        logic [5:0] idx;
        bit         miss;
        idx = a[9:4];
        if (fl) model_clear();
        miss = !(m_valid[idx] && (m_tag[idx] == a[31:10]));
        e.data = mem_word(a);
        e.miss = miss;
        sbq.push_back(e);
        if (miss) begin
            for (int w = 0; w < 4; w++) begin
                logic [1:0] wo;
                wo = w[1:0];
                addrq.push_back({a[31:4], wo, 2'b00});
            end
            if (validate) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = a[31:10];
            end
        end
        return miss;
    endfunction

    // Called on the negedge after the request; lat counts request cycle through done cycle.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 300; i++) begin
            if (bus.done) begin
                lat = i + 2;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within 300 cycles");
        end
    endtask

    task automatic issue(logic [31:0] a, logic [1:0] rw, bit fl, output int lat);
        bit miss;
        miss = predict(a, fl, 1'b1);
        bus.rw_flag = rw;
        bus.addr    = a;
        bus.flush   = fl;
        @(negedge clk);
        bus.rw_flag = 2'b00;
        bus.flush   = 1'b0;
        bus.addr    = $urandom;
        lat = 1;
        if (miss) begin
            wait_done(lat);
            @(negedge clk);
        end else begin
            check("hit_done_next_cycle", bus.done, 1'b1);
        end
    endtask

    task automatic wait_acks(int target);
        int n;
        n = 0;
        while (ack_count < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (ack_count < target) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: got %0d acks expected %0d", ack_count, target);
        end
    endtask

    // Memory responder: acks each word after cur_delay waiting cycles.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (!rst || !bus.mem_req) begin
                wait_cnt = 0;
            end else if (wait_cnt >= cur_delay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_word(bus.mem_addr);
                ack_count++;
                if (addrq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_mem_req: got addr 0x%0h expected no request",
                             bus.mem_addr);
                end else begin
                    check("mem_addr", bus.mem_addr, addrq.pop_front());
                end
                wait_cnt  = 0;
                cur_delay = rand_delay ? int'($urandom_range(0, 3)) : ack_delay;
            end else begin
                wait_cnt++;
            end
        end
    end

    // Monitor: pops the scoreboard on every done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                saw_busy = 1'b0;
            end else begin
                if (bus.busy) begin
                    saw_busy = 1'b1;
                    busy_cycles++;
                end
                if (bus.mem_req) mreq_cycles++;
                if (bus.done) begin
                    done_count++;
                    check("busy_low_with_done", bus.busy, 1'b0);
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: got done data 0x%0h expected none",
                                 bus.read_data);
                    end else begin
                        e = sbq.pop_front();
                        check("read_data", bus.read_data, e.data);
                        check("miss_flag", saw_busy, e.miss);
                    end
                    saw_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int b0, d0, m0, a0;
        bit miss;
        bus.rw_flag = 2'b00;
        bus.addr    = '0;
        bus.flush   = 1'b0;
        model_clear();

        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_read_data", bus.read_data, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // First miss with two wait cycles per word.
        ack_delay = 2;
        cur_delay = 2;
        b0 = busy_cycles;
        d0 = done_count;
        issue(32'h0000_0104, 2'b01, 1'b0, lat);
        check("miss_latency", lat, 14);
        check("refill_busy_cycles", busy_cycles - b0, 12);
        check("single_done", done_count - d0, 1);

        // Back-to-back hits over the filled line.
        m0 = mreq_cycles;
        for (int w = 0; w < 4; w++) begin
            issue(32'h0000_0100 + 32'(w * 4), 2'b01, 1'b0, lat);
        end
        check("b2b_no_mem_req", mreq_cycles - m0, 0);

        // Conflict on one index after an idle flush.
        bus.flush = 1'b1;
        model_clear();
        @(negedge clk);
        bus.flush = 1'b0;
        @(negedge clk);
        a0 = ack_count;
        ack_delay = 1;
        issue(32'h0000_0100, 2'b01, 1'b0, lat);
        issue(32'h0000_1100, 2'b11, 1'b0, lat);
        issue(32'h0000_0100, 2'b01, 1'b0, lat);
        check("conflict_acks", ack_count - a0, 12);

        // Flush arriving during the second refill word.
        issue(32'h0000_0104, 2'b01, 1'b0, lat);
        ack_delay = 2;
        miss = predict(32'h0000_0208, 1'b0, 1'b0);
        check("flush_case_is_miss", miss, 1'b1);
        a0 = ack_count;
        bus.rw_flag = 2'b01;
        bus.addr    = 32'h0000_0208;
        @(negedge clk);
        bus.rw_flag = 2'b00;
        wait_acks(a0 + 1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        wait_done(lat);
        @(negedge clk);
        model_clear();
        issue(32'h0000_0200, 2'b01, 1'b0, lat);
        issue(32'h0000_0100, 2'b01, 1'b0, lat);

        // Reset in the middle of a refill.
        bus.flush = 1'b1;
        model_clear();
        @(negedge clk);
        bus.flush = 1'b0;
        @(negedge clk);
        miss = predict(32'h0000_0108, 1'b0, 1'b0);
        a0 = ack_count;
        bus.rw_flag = 2'b01;
        bus.addr    = 32'h0000_0108;
        @(negedge clk);
        bus.rw_flag = 2'b00;
        wait_acks(a0 + 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_done", bus.done, 1'b0);
        check("midrst_mem_req", bus.mem_req, 1'b0);
        check("midrst_mem_addr", bus.mem_addr, 32'h0);
        check("midrst_read_data", bus.read_data, 32'h0);
        @(negedge clk);
        sbq.delete();
        addrq.delete();
        model_clear();
        rst = 1'b1;
        @(negedge clk);
        issue(32'h0000_0100, 2'b01, 1'b0, lat);

        // Write-only encoding is no request.
        d0 = done_count;
        m0 = mreq_cycles;
        b0 = busy_cycles;
        bus.addr = 32'h0000_0100;
        bus.rw_flag = 2'b10;
        repeat (5) @(negedge clk);
        bus.rw_flag = 2'b00;
        @(negedge clk);
        check("wr_no_done", done_count - d0, 0);
        check("wr_no_mem_req", mreq_cycles - m0, 0);
        check("wr_no_busy", busy_cycles - b0, 0);

        // Randomized traffic over a small address pool.
        rand_delay = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [1:0]  rw;
            bit          fl;
            int          kind;
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4)
                | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            rw = $urandom_range(0, 1) ? 2'b11 : 2'b01;
            fl = ($urandom_range(0, 15) == 0);
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                bus.flush = 1'b1;
                model_clear();
                @(negedge clk);
                bus.flush = 1'b0;
            end else if (kind == 1) begin
                bus.rw_flag = 2'b10;
                @(negedge clk);
                bus.rw_flag = 2'b00;
            end else begin
                issue(a, rw, fl, lat);
            end
        end
        repeat (3) @(negedge clk);

        check("scoreboard_drained", sbq.size(), 0);
        check("addr_queue_drained", addrq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
